// File: rtl/gavgpool_sched_if.sv
// Handshake bundle for the shared pooling scheduler: per-channel sample
// streams on the request side, one tagged result stream on the output side.
interface gavgpool_sched_if #(
    parameter int DATA_WIDTH = 12,
    parameter int NUM_CH     = 4
);
    localparam int CH_WIDTH = $clog2(NUM_CH);

    logic [NUM_CH-1:0]            ch_valid_in;
    logic [NUM_CH-1:0]            ch_ready_in;
    logic [NUM_CH*DATA_WIDTH-1:0] ch_data_in;
    logic                         out_ready;
    logic                         out_valid;
    logic [DATA_WIDTH-1:0]        out_data;
    logic [CH_WIDTH-1:0]          out_ch;

    modport master (
        output ch_valid_in, ch_data_in, out_ready,
        input  ch_ready_in, out_valid, out_data, out_ch
    );

    modport slave (
        input  ch_valid_in, ch_data_in, out_ready,
        output ch_ready_in, out_valid, out_data, out_ch
    );
endinterface

// File: rtl/gavgpool_sched.sv
// Round-robin scheduler sharing one global-average-pooling datapath among
// NUM_CH channels; each grant covers one full window, result tagged by channel.
module gavgpool_sched #(
    parameter int DATA_WIDTH = 12,
    parameter int POOL_SIZE  = 256,
    parameter int NUM_CH     = 4
) (
    input  logic             clk,
    input  logic             rst,
    gavgpool_sched_if.slave  bus
);
    localparam int CH_WIDTH  = $clog2(NUM_CH);
    localparam int SHIFT     = $clog2(POOL_SIZE);
    localparam int ACC_WIDTH = DATA_WIDTH + SHIFT;
    localparam int CNT_WIDTH = SHIFT;

    typedef enum logic {
        IDLE,
        POOL
    } state_t;

    state_t                 state_reg;
    logic [CH_WIDTH-1:0]    grant_reg;
    logic [CH_WIDTH-1:0]    last_grant_reg;
    logic [CNT_WIDTH-1:0]   count_reg;
    logic [ACC_WIDTH-1:0]   acc_reg;
    logic                   out_valid_reg;
    logic [DATA_WIDTH-1:0]  out_data_reg;
    logic [CH_WIDTH-1:0]    out_ch_reg;

    logic [DATA_WIDTH-1:0]  sample_arr [NUM_CH];
    logic [NUM_CH-1:0]      ready_vec;
    logic                   final_sample;
    logic                   slot_free;
    logic                   grant_ready;
    logic                   accept;
    logic [DATA_WIDTH-1:0]  sample;
    logic [ACC_WIDTH-1:0]   sum_next;
    logic                   any_req;
    logic [CH_WIDTH-1:0]    next_grant;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_unpack
            assign sample_arr[gi] = bus.ch_data_in[gi*DATA_WIDTH +: DATA_WIDTH];
        end
    endgenerate

    // The last sample of a window is only taken when the result register can
    // accept the new mean in the same cycle, so no result is ever overwritten.
    assign final_sample = (count_reg == CNT_WIDTH'(POOL_SIZE - 1));
    assign slot_free    = !out_valid_reg || bus.out_ready;
    assign grant_ready  = (state_reg == POOL) && (!final_sample || slot_free);

    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_ready
            assign ready_vec[gi] = grant_ready && (grant_reg == CH_WIDTH'(gi));
        end
    endgenerate

    assign bus.ch_ready_in = ready_vec;
    assign sample          = sample_arr[grant_reg];
    assign accept          = grant_ready && bus.ch_valid_in[grant_reg];
    assign sum_next        = acc_reg + ACC_WIDTH'(sample);
    assign any_req         = |bus.ch_valid_in;

    // Round-robin pick: lowest requester above last_grant, else lowest overall.
    always_comb begin
        logic [CH_WIDTH-1:0] hi_idx;
        logic [CH_WIDTH-1:0] lo_idx;
        logic                hi_found;
        hi_idx   = '0;
        lo_idx   = '0;
        hi_found = 1'b0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (bus.ch_valid_in[i]) begin
                lo_idx = CH_WIDTH'(i);
                if (i > int'(last_grant_reg)) begin
                    hi_idx   = CH_WIDTH'(i);
                    hi_found = 1'b1;
                end
            end
        end
        next_grant = hi_found ? hi_idx : lo_idx;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= IDLE;
            grant_reg      <= '0;
            last_grant_reg <= CH_WIDTH'(NUM_CH - 1);
            count_reg      <= '0;
            acc_reg        <= '0;
            out_valid_reg  <= 1'b0;
            out_data_reg   <= '0;
            out_ch_reg     <= '0;
        end else begin
            // A result loaded below in the same cycle overrides this clear.
            if (out_valid_reg && bus.out_ready) begin
                out_valid_reg <= 1'b0;
            end
            case (state_reg)
                IDLE: begin
                    if (any_req) begin
                        grant_reg      <= next_grant;
                        last_grant_reg <= next_grant;
                        acc_reg        <= '0;
                        count_reg      <= '0;
                        state_reg      <= POOL;
                    end
                end
                POOL: begin
                    if (accept) begin
                        if (final_sample) begin
                            out_data_reg  <= sum_next[ACC_WIDTH-1:SHIFT];
                            out_ch_reg    <= grant_reg;
                            out_valid_reg <= 1'b1;
                            acc_reg       <= '0;
                            count_reg     <= '0;
                            state_reg     <= IDLE;
                        end else begin
                            acc_reg   <= sum_next;
                            count_reg <= count_reg + CNT_WIDTH'(1);
                        end
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign bus.out_valid = out_valid_reg;
    assign bus.out_data  = out_data_reg;
    assign bus.out_ch    = out_ch_reg;
endmodule

// File: tb/tb_gavgpool_sched.sv
// Directed bench for gavgpool_sched with POOL_SIZE=4, NUM_CH=4, DATA_WIDTH=12.
module tb_gavgpool_sched;
    localparam int DW = 12;
    localparam int PS = 4;
    localparam int NC = 4;

    logic clk = 1'b0;
    logic rst;
    int   tests;
    int   fails;

    always #5 clk = ~clk;

    gavgpool_sched_if #(.DATA_WIDTH(DW), .NUM_CH(NC)) bus ();

    gavgpool_sched #(.DATA_WIDTH(DW), .POOL_SIZE(PS), .NUM_CH(NC)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic set_ch(input int ch, input logic [DW-1:0] v);
        bus.ch_data_in[ch*DW +: DW] = v;
    endtask

    task automatic do_reset();
        bus.ch_valid_in = '0;
        bus.ch_data_in  = '0;
        bus.out_ready   = 1'b1;
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic run_window(input int ch, input logic [DW-1:0] d0, input logic [DW-1:0] d1,
                              input logic [DW-1:0] d2, input logic [DW-1:0] d3,
                              output logic [DW-1:0] rd, output logic [1:0] rc, output bit got);
        logic [DW-1:0] d [4];
        int n;
        bit acc;
        d[0] = d0; d[1] = d1; d[2] = d2; d[3] = d3;
        n = 0; got = 1'b0; rd = '0; rc = '0;
        bus.out_ready       = 1'b1;
        bus.ch_valid_in     = '0;
        bus.ch_valid_in[ch] = 1'b1;
        for (int c = 0; c < 20 && n < 4; c++) begin
            set_ch(ch, d[n]);
            settle();
            acc = bus.ch_ready_in[ch];
            step();
            if (acc) n++;
        end
        bus.ch_valid_in = '0;
        settle();
        if (n == 4 && bus.out_valid) begin
            got = 1'b1;
            rd  = bus.out_data;
            rc  = bus.out_ch;
            $display("[TB] result ch=%0d data=%0d", rc, rd);
        end
        step();
    endtask

    task automatic test_reset();
        bus.ch_data_in  = '0;
        bus.out_ready   = 1'b0;
        bus.ch_valid_in = 4'b1111;
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        bus.ch_valid_in = '0;
        settle();
        tests++; if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid: got %0b expected 0", bus.out_valid); end
        tests++; if (bus.out_data !== 12'd0) begin fails++; $display("FAIL reset_out_data: got %0d expected 0", bus.out_data); end
        tests++; if (bus.out_ch !== 2'd0) begin fails++; $display("FAIL reset_out_ch: got %0d expected 0", bus.out_ch); end
        tests++; if (bus.ch_ready_in !== 4'b0000) begin fails++; $display("FAIL reset_ready: got %b expected 0000", bus.ch_ready_in); end
        step();
    endtask

    task automatic test_single();
        logic [DW-1:0] vals [4];
        vals[0] = 12'd1; vals[1] = 12'd2; vals[2] = 12'd3; vals[3] = 12'd6;
        do_reset();
        bus.ch_valid_in = 4'b0001;
        set_ch(0, vals[0]);
        settle();
        tests++; if (bus.ch_ready_in !== 4'b0000) begin fails++; $display("FAIL single_idle_ready: got %b expected 0000", bus.ch_ready_in); end
        step();
        for (int k = 0; k < 4; k++) begin
            set_ch(0, vals[k]);
            settle();
            tests++; if (bus.ch_ready_in !== 4'b0001) begin fails++; $display("FAIL single_ready[%0d]: got %b expected 0001", k, bus.ch_ready_in); end
            tests++; if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL single_early_valid[%0d]: got %0b expected 0", k, bus.out_valid); end
            step();
        end
        bus.ch_valid_in = '0;
        settle();
        $display("[TB] result ch=%0d data=%0d", bus.out_ch, bus.out_data);
        tests++; if (bus.out_valid !== 1'b1) begin fails++; $display("FAIL single_valid: got %0b expected 1", bus.out_valid); end
        tests++; if (bus.out_data !== 12'd3) begin fails++; $display("FAIL single_data: got %0d expected 3", bus.out_data); end
        tests++; if (bus.out_ch !== 2'd0) begin fails++; $display("FAIL single_ch: got %0d expected 0", bus.out_ch); end
        step();
        settle();
        tests++; if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL single_consumed: got %0b expected 0", bus.out_valid); end
    endtask

    task automatic test_round_robin();
        logic [DW-1:0] exp_d [5];
        logic [1:0]    exp_c [5];
        int nres;
        int last_c;
        exp_d[0] = 12'd10; exp_d[1] = 12'd20; exp_d[2] = 12'd30; exp_d[3] = 12'd40; exp_d[4] = 12'd10;
        exp_c[0] = 2'd0;   exp_c[1] = 2'd1;   exp_c[2] = 2'd2;   exp_c[3] = 2'd3;   exp_c[4] = 2'd0;
        nres = 0;
        last_c = -1;
        do_reset();
        bus.ch_valid_in = 4'b1111;
        for (int i = 0; i < NC; i++) set_ch(i, DW'(10 * (i + 1)));
        for (int c = 0; c < 26; c++) begin
            settle();
            tests++; if ($countones(bus.ch_ready_in) > 1) begin fails++; $display("FAIL rr_onehot[c%0d]: got %b expected at most one bit", c, bus.ch_ready_in); end
            if (bus.out_valid) begin
                $display("[TB] result ch=%0d data=%0d cycle=%0d", bus.out_ch, bus.out_data, c);
                if (nres < 5) begin
                    tests++; if (bus.out_data !== exp_d[nres]) begin fails++; $display("FAIL rr_data[%0d]: got %0d expected %0d", nres, bus.out_data, exp_d[nres]); end
                    tests++; if (bus.out_ch !== exp_c[nres]) begin fails++; $display("FAIL rr_ch[%0d]: got %0d expected %0d", nres, bus.out_ch, exp_c[nres]); end
                end
                if (last_c >= 0) begin
                    tests++; if (c - last_c != 5) begin fails++; $display("FAIL rr_spacing[%0d]: got %0d expected 5", nres, c - last_c); end
                end
                last_c = c;
                nres++;
            end
            step();
        end
        bus.ch_valid_in = '0;
        tests++; if (nres != 5) begin fails++; $display("FAIL rr_count: got %0d expected 5", nres); end
    endtask

    task automatic test_extremes();
        logic [DW-1:0] rd;
        logic [1:0]    rc;
        bit            got;
        do_reset();
        run_window(2, 12'd4095, 12'd4095, 12'd4095, 12'd4095, rd, rc, got);
        tests++; if (got !== 1'b1) begin fails++; $display("FAIL max_got: got %0b expected 1", got); end
        tests++; if (rd !== 12'd4095) begin fails++; $display("FAIL max_data: got %0d expected 4095", rd); end
        tests++; if (rc !== 2'd2) begin fails++; $display("FAIL max_ch: got %0d expected 2", rc); end
        run_window(2, 12'd1, 12'd0, 12'd0, 12'd0, rd, rc, got);
        tests++; if (got !== 1'b1) begin fails++; $display("FAIL floor_got: got %0b expected 1", got); end
        tests++; if (rd !== 12'd0) begin fails++; $display("FAIL floor_data: got %0d expected 0", rd); end
        tests++; if (rc !== 2'd2) begin fails++; $display("FAIL floor_ch: got %0d expected 2", rc); end
    endtask

    task automatic test_backpressure();
        logic [3:0]    exp_r;
        logic          exp_v;
        logic [DW-1:0] exp_d;
        logic [1:0]    exp_c;
        do_reset();
        bus.out_ready   = 1'b0;
        bus.ch_valid_in = 4'b0011;
        set_ch(0, 12'd8);
        set_ch(1, 12'd20);
        for (int c = 0; c < 16; c++) begin
            if (c == 13) bus.out_ready = 1'b1;
            if (c == 14) bus.ch_valid_in = '0;
            settle();
            if (c >= 1 && c <= 4)                exp_r = 4'b0001;
            else if ((c >= 6 && c <= 8) || c == 13) exp_r = 4'b0010;
            else                                 exp_r = 4'b0000;
            exp_v = (c >= 5 && c <= 14);
            exp_d = (c == 14) ? 12'd20 : 12'd8;
            exp_c = (c == 14) ? 2'd1 : 2'd0;
            tests++; if (bus.ch_ready_in !== exp_r) begin fails++; $display("FAIL bp_ready[c%0d]: got %b expected %b", c, bus.ch_ready_in, exp_r); end
            tests++; if (bus.out_valid !== exp_v) begin fails++; $display("FAIL bp_valid[c%0d]: got %0b expected %0b", c, bus.out_valid, exp_v); end
            if (exp_v) begin
                tests++; if (bus.out_data !== exp_d) begin fails++; $display("FAIL bp_data[c%0d]: got %0d expected %0d", c, bus.out_data, exp_d); end
                tests++; if (bus.out_ch !== exp_c) begin fails++; $display("FAIL bp_ch[c%0d]: got %0d expected %0d", c, bus.out_ch, exp_c); end
            end
            if (c == 5 || c == 14) $display("[TB] result ch=%0d data=%0d cycle=%0d", bus.out_ch, bus.out_data, c);
            step();
        end
        bus.out_ready = 1'b1;
    endtask

    task automatic test_no_preempt();
        logic [DW-1:0] vals [4];
        logic [3:0]    exp_r;
        int n;
        vals[0] = 12'd5; vals[1] = 12'd7; vals[2] = 12'd9; vals[3] = 12'd11;
        n = 0;
        do_reset();
        set_ch(3, 12'd100);
        for (int c = 0; c < 10; c++) begin
            bus.ch_valid_in    = 4'b1000;
            bus.ch_valid_in[1] = !(c >= 3 && c <= 5);
            set_ch(1, (n < 4) ? vals[n] : 12'd0);
            settle();
            if (c >= 1 && c <= 7) exp_r = 4'b0010;
            else if (c == 9)      exp_r = 4'b1000;
            else                  exp_r = 4'b0000;
            tests++; if (bus.ch_ready_in !== exp_r) begin fails++; $display("FAIL np_ready[c%0d]: got %b expected %b", c, bus.ch_ready_in, exp_r); end
            if (c == 8) begin
                $display("[TB] result ch=%0d data=%0d", bus.out_ch, bus.out_data);
                tests++; if (bus.out_valid !== 1'b1) begin fails++; $display("FAIL np_valid: got %0b expected 1", bus.out_valid); end
                tests++; if (bus.out_data !== 12'd8) begin fails++; $display("FAIL np_data: got %0d expected 8", bus.out_data); end
                tests++; if (bus.out_ch !== 2'd1) begin fails++; $display("FAIL np_ch: got %0d expected 1", bus.out_ch); end
            end else if (c < 8) begin
                tests++; if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL np_early_valid[c%0d]: got %0b expected 0", c, bus.out_valid); end
            end
            if (bus.ch_valid_in[1] && bus.ch_ready_in[1]) n++;
            step();
        end
        bus.ch_valid_in = '0;
    endtask

    task automatic test_reset_mid();
        logic [3:0] exp_r;
        do_reset();
        bus.ch_valid_in = 4'b0001;
        set_ch(0, 12'd50);
        step();
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        bus.ch_valid_in = 4'b1001;
        set_ch(0, 12'd4);
        set_ch(3, 12'd200);
        for (int c = 0; c < 6; c++) begin
            settle();
            exp_r = (c >= 1 && c <= 4) ? 4'b0001 : 4'b0000;
            tests++; if (bus.ch_ready_in !== exp_r) begin fails++; $display("FAIL rm_ready[c%0d]: got %b expected %b", c, bus.ch_ready_in, exp_r); end
            if (c < 5) begin
                tests++; if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL rm_spurious[c%0d]: got %0b expected 0", c, bus.out_valid); end
            end else begin
                $display("[TB] result ch=%0d data=%0d", bus.out_ch, bus.out_data);
                tests++; if (bus.out_valid !== 1'b1) begin fails++; $display("FAIL rm_valid: got %0b expected 1", bus.out_valid); end
                tests++; if (bus.out_data !== 12'd4) begin fails++; $display("FAIL rm_data: got %0d expected 4", bus.out_data); end
                tests++; if (bus.out_ch !== 2'd0) begin fails++; $display("FAIL rm_ch: got %0d expected 0", bus.out_ch); end
                bus.ch_valid_in = '0;
                bus.out_ready   = 1'b0;
                rst = 1'b1;
            end
            step();
        end
        rst = 1'b0;
        settle();
        tests++; if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL rm_drop_valid: got %0b expected 0", bus.out_valid); end
        tests++; if (bus.out_data !== 12'd0) begin fails++; $display("FAIL rm_drop_data: got %0d expected 0", bus.out_data); end
        bus.out_ready = 1'b1;
        step();
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rst   = 1'b1;
        bus.ch_valid_in = '0;
        bus.ch_data_in  = '0;
        bus.out_ready   = 1'b0;
        test_reset();
        test_single();
        test_round_robin();
        test_extremes();
        test_backpressure();
        test_no_preempt();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/gavgpool_sched.md
# gavgpool_sched

Round-robin scheduler that shares one global-average-pooling datapath (accumulate, then shift by log2 POOL_SIZE) between NUM_CH independent channel streams. It grants one channel at a time for a complete window of POOL_SIZE samples, then emits the floor mean tagged with the channel index. It sits between the per-channel convolution outputs and the classifier stage, and replaces NUM_CH separate pooling instances.

## Interface
- DATA_WIDTH, 12, width of each unsigned sample and of the result
- POOL_SIZE, 256, samples per window; power of two, ≥2
- NUM_CH, 4, number of requesting channels, ≥2
- CH_WIDTH (localparam), clog2(NUM_CH), width of channel tag
- ACC_WIDTH (localparam), DATA_WIDTH+clog2(POOL_SIZE), accumulator width

Ports:
- clk  in  1  clock
- rst  in  1  reset: synchronous, active-high
- ch_valid_in  in  NUM_CH  per-channel sample valid
- ch_ready_in  out  NUM_CH  per-channel ready; at most one bit set
- ch_data_in  in  NUM_CH*DATA_WIDTH  packed samples; channel i at [i*DATA_WIDTH +: DATA_WIDTH]
- out_ready  in  1  downstream ready
- out_valid  out  1  result valid
- out_data  out  DATA_WIDTH  window mean
- out_ch  out  CH_WIDTH  channel the result belongs to

## Operation
- FSM has 2 states: IDLE and POOL.
- IDLE:
  - All ch_ready_in are 0.
  - If any ch_valid_in is set, grant the first requesting channel searching upward (with wrap) from last_grant+1.
  - Register the grant index, set last_grant to it, clear the accumulator and counter, and go to POOL.
  - If no channel requests, stay in IDLE.
- POOL:
  - ch_ready_in[grant] = 1 except on the final sample (count == POOL_SIZE-1). On that sample it is 1 only if out_valid==0 or out_ready==1 (output slot free this cycle).
  - All other ready bits are 0. A request from another channel never preempts the granted channel.
  - On accept (valid&&ready): accumulator += zero-extended sample, and count++.
  - Final accept:
    - out_data <= (accumulator + sample) >> clog2(POOL_SIZE), truncated to DATA_WIDTH.
    - out_ch <= grant and out_valid <= 1.
    - Go to IDLE.
- Arithmetic is unsigned and ACC_WIDTH wide. The sum cannot overflow. The result is the floor mean.
- Output register:
  - out_valid clears on out_valid&&out_ready unless a new result loads the same cycle; in that case it stays 1 with the new data.
  - out_data and out_ch are stable while out_valid && !out_ready.
- Reset values:
  - State IDLE, count 0, accumulator 0, grant 0.
  - last_grant = NUM_CH-1, so channel 0 has first priority.
  - out_valid 0, out_data 0, out_ch 0, ch_ready_in 0.
- Reset mid-window discards the partial sum and produces no output. Reset while out_valid is set drops the pending result.

## Timing
- Arbitration takes 1 cycle: IDLE at cycle t, first sample can be accepted at t+1.
- Result latency: out_valid rises the cycle after the final accept.
- Peak throughput: one result per POOL_SIZE+1 cycles with continuous valid.
- Back-to-back results need no bubble if out_ready is held high.
- Counter wraps: count returns to 0 when IDLE is entered; no stale count carries over.
- ch_ready_in is combinational from state, count, out_valid and out_ready. It does not depend on ch_valid_in.
- Simultaneous final accept and output consume: the new result replaces the old in the same cycle, with no loss or duplication.

## Test plan
Test parameters: POOL_SIZE=4, NUM_CH=4, DATA_WIDTH=12.
1. Only ch0 valid, samples 1,2,3,6, out_ready=1 -> ch_ready_in=0001 for 4 accepts. out_valid one cycle after the 4th accept with out_data=3, out_ch=0.
2. All channels valid continuously, channel i sends value 10*(i+1) -> results in order ch0=10, ch1=20, ch2=30, ch3=40, then ch0 again. Never more than one ready bit set. Each window spans 5 cycles.
3. ch2 sends 4095 x4 -> out_data=4095, out_ch=2 (no overflow). ch2 sends 1,0,0,0 -> out_data=0 (floor).
4. out_ready=0, two channels valid -> first result held stable. The second window accepts 3 samples, then its ready stays 0 until out_ready rises. The 4th sample is accepted in that same cycle and the second result follows next cycle.
5. Granted ch1 drops valid for 3 cycles mid-window while ch3 is valid -> ch1 keeps the grant, count pauses, ch3 is granted only after ch1's window ends. ch1 result is correct.
6. rst asserted after 2 samples of ch0 -> no output. After reset, ch3 and ch0 both valid -> ch0 granted first, and its window sum excludes the discarded samples.
